pulse_gen_multi_core: RTL and testbench

Multi-channel successor of the single-channel pulse generator, running entirely in one clock domain with no internal clock-domain crossing. Each of NCH channels has its own delay, width, period, repeat and fine-phase settings. Each channel drives an SER_WIDTH-bit parallel word per clock to an external serializer. Start and stop act on a channel mask, and each channel reports its own done flag.

---
 rtl/pulse_gen_multi_core_if.sv | 13 +
 rtl/pulse_gen_multi_core.sv | 227 ++++++++++++++++++++++
 tb/tb_pulse_gen_multi_core.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_gen_multi_core_if.sv
// Register bus of pulse_gen_multi_core: address, write data, strobes and registered read data.
interface pulse_gen_multi_core_if #(
  parameter int ABUSWIDTH = 16
);
  logic [ABUSWIDTH-1:0] BUS_ADD;
  logic [7:0]           BUS_DATA_IN;
  logic                 BUS_RD;
  logic                 BUS_WR;
  logic [7:0]           BUS_DATA_OUT;

  modport master (output BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR, input BUS_DATA_OUT);
  modport slave  (input BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR, output BUS_DATA_OUT);
endinterface

// File: rtl/pulse_gen_multi_core.sv
// Multi-channel pulse generator emitting per-channel SER_WIDTH-bit words for an external serializer.
// Define PULSE_GEN_MULTI_EXT_TRIG_EN to enable synchronized per-channel EXT_START triggers.
module pulse_gen_multi_core #(
  parameter int         ABUSWIDTH = 16,
  parameter int         NCH       = 4,
  parameter int         SER_WIDTH = 8,
  parameter logic [7:0] VERSION   = 8'd2
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST_N,
  pulse_gen_multi_core_if.slave    bus,
  input  logic [NCH-1:0]           EXT_START,
  output logic [NCH*SER_WIDTH-1:0] PULSE_WORD,
  output logic [NCH-1:0]           PULSE_REF,
  output logic [NCH-1:0]           DONE
);

  typedef enum logic {CH_IDLE, CH_RUN} chState_e;

  logic                 inv_q    [NCH], inv_d    [NCH];
  logic [31:0]          delay_q  [NCH], delay_d  [NCH];
  logic [31:0]          width_q  [NCH], width_d  [NCH];
  logic [31:0]          period_q [NCH], period_d [NCH];
  logic [15:0]          repeat_q [NCH], repeat_d [NCH];
  logic [15:0]          phase_q  [NCH], phase_d  [NCH];
  logic [31:0]          cnt_q    [NCH], cnt_d    [NCH];
  logic [15:0]          rcnt_q   [NCH], rcnt_d   [NCH];
  chState_e             state_q  [NCH], state_d  [NCH];
  logic [SER_WIDTH-1:0] word_q   [NCH], word_d   [NCH];
  logic [NCH-1:0]       ref_q, ref_d;
  logic [7:0]           dataOut_q, dataOut_d;

  logic [31:0]          effPeriod [NCH];
  logic [SER_WIDTH-1:0] rawWord   [NCH];
  logic [NCH-1:0]       rawRef, extTrig, extEnRd, doneVec, chanWr, chanRd;
  logic [NCH-1:0]       startMask, stopMask;
  logic                 softRst;
  logic [4:0]           regOff;
  logic [ABUSWIDTH-6:0] chanIdx;

  assign softRst   = bus.BUS_WR && (bus.BUS_ADD == '0);
  assign startMask = (bus.BUS_WR && bus.BUS_ADD == ABUSWIDTH'(1)) ? bus.BUS_DATA_IN[NCH-1:0] : '0;
  assign stopMask  = (bus.BUS_WR && bus.BUS_ADD == ABUSWIDTH'(2)) ? bus.BUS_DATA_IN[NCH-1:0] : '0;
  assign regOff    = bus.BUS_ADD[4:0];
  assign chanIdx   = bus.BUS_ADD[ABUSWIDTH-1:5];
  assign bus.BUS_DATA_OUT = dataOut_q;
  assign DONE      = doneVec;
  assign PULSE_REF = ref_q;

  // The burst length covers the whole pulse even when PERIOD is shorter; the sum saturates at 2^32-1.
  for (genvar g = 0; g < NCH; g++) begin : gChan
    logic [32:0] dwSum;
    logic [31:0] dwSat;
    logic        inPulse;
    assign dwSum   = {1'b0, delay_q[g]} + {1'b0, width_q[g]};
    assign dwSat   = dwSum[32] ? '1 : dwSum[31:0];
    assign inPulse = (delay_q[g] != '0) && (width_q[g] != '0) && ({1'b0, cnt_q[g]} < dwSum);
    assign effPeriod[g] = (period_q[g] > dwSat) ? period_q[g] : dwSat;
    assign rawRef[g]    = inPulse && (cnt_q[g] >= delay_q[g]);
    assign rawWord[g]   = !inPulse                   ? '0 :
                          (cnt_q[g] == delay_q[g])   ? phase_q[g][SER_WIDTH-1:0] :
                          (cnt_q[g] >  delay_q[g])   ? '1 : '0;
    assign chanWr[g]  = bus.BUS_WR && (chanIdx == (ABUSWIDTH-5)'(g + 1));
    assign chanRd[g]  = bus.BUS_RD && (chanIdx == (ABUSWIDTH-5)'(g + 1));
    assign doneVec[g] = (state_q[g] == CH_IDLE);
    assign PULSE_WORD[g*SER_WIDTH +: SER_WIDTH] = word_q[g];
  end

`ifdef PULSE_GEN_MULTI_EXT_TRIG_EN
  logic       extEn_q   [NCH], extEn_d   [NCH];
  logic [2:0] extSync_q [NCH], extSync_d [NCH];

  // Two flops synchronize, the third holds the previous level for rising-edge detection.
  for (genvar g = 0; g < NCH; g++) begin : gExt
    assign extTrig[g] = extEn_q[g] && extSync_q[g][1] && !extSync_q[g][2];
    assign extEnRd[g] = extEn_q[g];
  end

  always_comb begin
    extEn_d   = extEn_q;
    extSync_d = extSync_q;
    for (int i = 0; i < NCH; i++) begin
      extSync_d[i] = {extSync_q[i][1:0], EXT_START[i]};
      if (chanWr[i] && regOff == 5'd0) extEn_d[i] = bus.BUS_DATA_IN[0];
      if (softRst) begin
        extEn_d[i]   = 1'b0;
        extSync_d[i] = '0;
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      for (int i = 0; i < NCH; i++) begin
        extEn_q[i]   <= 1'b0;
        extSync_q[i] <= '0;
      end
    end else begin
      extEn_q   <= extEn_d;
      extSync_q <= extSync_d;
    end
  end
`else
  logic unusedExtStart;
  assign unusedExtStart = ^EXT_START;
  assign extTrig = '0;
  assign extEnRd = '0;
`endif

  always_comb begin
    inv_d    = inv_q;
    delay_d  = delay_q;
    width_d  = width_q;
    period_d = period_q;
    repeat_d = repeat_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    rcnt_d   = rcnt_q;
    state_d  = state_q;
    word_d   = word_q;
    ref_d    = ref_q;
    dataOut_d = dataOut_q;
    if (bus.BUS_RD) begin
      dataOut_d = '0;
      if (bus.BUS_ADD == '0)                dataOut_d = VERSION;
      else if (bus.BUS_ADD == ABUSWIDTH'(1)) dataOut_d = 8'(doneVec);
    end
    for (int i = 0; i < NCH; i++) begin
      if (chanWr[i]) begin
        if (regOff == 5'd0)                         inv_d[i] = bus.BUS_DATA_IN[1];
        else if (regOff >= 5'd2  && regOff <= 5'd5)  delay_d[i][8*int'(regOff - 5'd2) +: 8]   = bus.BUS_DATA_IN;
        else if (regOff >= 5'd6  && regOff <= 5'd9)  width_d[i][8*int'(regOff - 5'd6) +: 8]   = bus.BUS_DATA_IN;
        else if (regOff >= 5'd10 && regOff <= 5'd13) period_d[i][8*int'(regOff - 5'd10) +: 8] = bus.BUS_DATA_IN;
        else if (regOff >= 5'd14 && regOff <= 5'd15) repeat_d[i][8*int'(regOff - 5'd14) +: 8] = bus.BUS_DATA_IN;
        else if (regOff >= 5'd16 && regOff <= 5'd17) phase_d[i][8*int'(regOff - 5'd16) +: 8]  = bus.BUS_DATA_IN;
      end
      if (chanRd[i]) begin
        if (regOff == 5'd0)                         dataOut_d = {6'd0, inv_q[i], extEnRd[i]};
        else if (regOff >= 5'd2  && regOff <= 5'd5)  dataOut_d = delay_q[i][8*int'(regOff - 5'd2) +: 8];
        else if (regOff >= 5'd6  && regOff <= 5'd9)  dataOut_d = width_q[i][8*int'(regOff - 5'd6) +: 8];
        else if (regOff >= 5'd10 && regOff <= 5'd13) dataOut_d = period_q[i][8*int'(regOff - 5'd10) +: 8];
        else if (regOff >= 5'd14 && regOff <= 5'd15) dataOut_d = repeat_q[i][8*int'(regOff - 5'd14) +: 8];
        else if (regOff >= 5'd16 && regOff <= 5'd17) dataOut_d = phase_q[i][8*int'(regOff - 5'd16) +: 8];
        else if (regOff >= 5'd18 && regOff <= 5'd21) dataOut_d = cnt_q[i][8*int'(regOff - 5'd18) +: 8];
      end

      // Outputs follow the counter one cycle later; the idle word is never inverted.
      word_d[i] = '0;
      ref_d[i]  = 1'b0;
      if (state_q[i] == CH_RUN) begin
        word_d[i] = inv_q[i] ? ~rawWord[i] : rawWord[i];
        ref_d[i]  = rawRef[i];
        if (cnt_q[i] >= effPeriod[i]) begin
          if (rcnt_q[i] == 16'd1) begin
            state_d[i] = CH_IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = 32'd1;
            if (rcnt_q[i] != '0) rcnt_d[i] = rcnt_q[i] - 16'd1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 32'd1;
        end
      end
      if (startMask[i] || extTrig[i]) begin
        state_d[i] = CH_RUN;
        cnt_d[i]   = 32'd1;
        rcnt_d[i]  = repeat_q[i];
        word_d[i]  = '0;
        ref_d[i]   = 1'b0;
      end
      if (stopMask[i]) begin
        state_d[i] = CH_IDLE;
        cnt_d[i]   = '0;
        word_d[i]  = '0;
        ref_d[i]   = 1'b0;
      end
      if (softRst) begin
        inv_d[i]    = 1'b0;
        delay_d[i]  = '0;
        width_d[i]  = '0;
        period_d[i] = '0;
        repeat_d[i] = 16'd1;
        phase_d[i]  = '0;
        cnt_d[i]    = '0;
        rcnt_d[i]   = '0;
        state_d[i]  = CH_IDLE;
        word_d[i]   = '0;
        ref_d[i]    = 1'b0;
      end
    end
    if (softRst) dataOut_d = '0;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      for (int i = 0; i < NCH; i++) begin
        inv_q[i]    <= 1'b0;
        delay_q[i]  <= '0;
        width_q[i]  <= '0;
        period_q[i] <= '0;
        repeat_q[i] <= 16'd1;
        phase_q[i]  <= '0;
        cnt_q[i]    <= '0;
        rcnt_q[i]   <= '0;
        state_q[i]  <= CH_IDLE;
        word_q[i]   <= '0;
      end
      ref_q     <= '0;
      dataOut_q <= '0;
    end else begin
      inv_q     <= inv_d;
      delay_q   <= delay_d;
      width_q   <= width_d;
      period_q  <= period_d;
      repeat_q  <= repeat_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      state_q   <= state_d;
      word_q    <= word_d;
      ref_q     <= ref_d;
      dataOut_q <= dataOut_d;
    end
  end

endmodule

// File: tb/tb_pulse_gen_multi_core.sv
// Randomized self-checking bench for pulse_gen_multi_core against a burst-arithmetic reference model.
module tb_pulse_gen_multi_core;
  localparam int NCH = 4;
  localparam int SW  = 8;

  logic              clk  = 1'b0;
  logic              rstN = 1'b0;
  logic [NCH-1:0]    extStart = '0;
  logic [NCH*SW-1:0] pulseWord;
  logic [NCH-1:0]    pulseRef;
  logic [NCH-1:0]    done;
  logic [7:0]        rd;

  int     testCount = 0;
  int     failCount = 0;
  longint cyc = 0;

  // Reference model: configuration per channel plus the edge index at which it was last started.
  longint cfgDelay [NCH], cfgWidth [NCH], cfgPeriod [NCH], cfgRepeat [NCH], cfgPhase [NCH];
  bit     cfgInv   [NCH];
  longint chStart  [NCH];

  pulse_gen_multi_core_if #(.ABUSWIDTH(16)) busIf ();

  pulse_gen_multi_core #(.ABUSWIDTH(16), .NCH(NCH), .SER_WIDTH(SW), .VERSION(8'd2)) dut (
    .BUS_CLK    (clk),
    .BUS_RST_N  (rstN),
    .bus        (busIf),
    .EXT_START  (extStart),
    .PULSE_WORD (pulseWord),
    .PULSE_REF  (pulseRef),
    .DONE       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint effP(input int ch);
    longint dw;
    dw = cfgDelay[ch] + cfgWidth[ch];
    return (cfgPeriod[ch] > dw) ? cfgPeriod[ch] : dw;
  endfunction

  // A started channel runs for REPEAT*P edges (forever if REPEAT is 0).
  function automatic bit runningAfter(input int ch, input longint s);
    if (chStart[ch] < 0) return 1'b0;
    if (cfgRepeat[ch] == 0) return 1'b1;
    return s < cfgRepeat[ch] * effP(ch);
  endfunction

  function automatic longint countAt(input int ch, input longint s);
    return (s % effP(ch)) + 1;
  endfunction

  function automatic logic [SW-1:0] expWord(input int ch);
    longint s, c;
    logic [SW-1:0] w;
    s = cyc - chStart[ch];
    if (chStart[ch] < 0 || s < 1 || !runningAfter(ch, s - 1)) return '0;
    c = countAt(ch, s - 1);
    w = '0;
    if (cfgDelay[ch] != 0 && cfgWidth[ch] != 0) begin
      if (c == cfgDelay[ch]) w = SW'(cfgPhase[ch]);
      else if (c > cfgDelay[ch] && c < cfgDelay[ch] + cfgWidth[ch]) w = '1;
    end
    return cfgInv[ch] ? ~w : w;
  endfunction

  function automatic bit expRef(input int ch);
    longint s, c;
    s = cyc - chStart[ch];
    if (chStart[ch] < 0 || s < 1 || !runningAfter(ch, s - 1)) return 1'b0;
    if (cfgDelay[ch] == 0 || cfgWidth[ch] == 0) return 1'b0;
    c = countAt(ch, s - 1);
    return (c >= cfgDelay[ch]) && (c < cfgDelay[ch] + cfgWidth[ch]);
  endfunction

  function automatic bit expDone(input int ch);
    return !runningAfter(ch, cyc - chStart[ch]);
  endfunction

  task automatic modelReset();
    for (int ch = 0; ch < NCH; ch++) begin
      cfgDelay[ch] = 0; cfgWidth[ch] = 0; cfgPeriod[ch] = 0;
      cfgRepeat[ch] = 1; cfgPhase[ch] = 0; cfgInv[ch] = 1'b0;
      chStart[ch] = -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [7:0] d);
    busIf.BUS_ADD = a; busIf.BUS_DATA_IN = d; busIf.BUS_WR = 1'b1;
    step();
    busIf.BUS_WR = 1'b0;
  endtask

  task automatic busRead(input logic [15:0] a, output logic [7:0] d);
    busIf.BUS_ADD = a; busIf.BUS_RD = 1'b1;
    step();
    busIf.BUS_RD = 1'b0;
    d = busIf.BUS_DATA_OUT;
  endtask

  task automatic writeCfg(input int ch, input longint d, input longint w, input longint p,
                          input longint r, input longint ph, input bit inv);
    logic [15:0] base;
    logic [31:0] v;
    base = 16'(32 * (ch + 1));
    busWrite(base, {6'd0, inv, 1'b0});
    for (int k = 0; k < 4; k++) begin
      v = 32'(d); busWrite(base + 16'(2 + k), v[8*k +: 8]);
      v = 32'(w); busWrite(base + 16'(6 + k), v[8*k +: 8]);
      v = 32'(p); busWrite(base + 16'(10 + k), v[8*k +: 8]);
    end
    for (int k = 0; k < 2; k++) begin
      v = 32'(r);  busWrite(base + 16'(14 + k), v[8*k +: 8]);
      v = 32'(ph); busWrite(base + 16'(16 + k), v[8*k +: 8]);
    end
    cfgDelay[ch] = d; cfgWidth[ch] = w; cfgPeriod[ch] = p;
    cfgRepeat[ch] = r; cfgPhase[ch] = ph; cfgInv[ch] = inv;
  endtask

  task automatic checkAll();
    for (int ch = 0; ch < NCH; ch++) begin
      checkOutput($sformatf("word%0d@%0d", ch, cyc), 32'(pulseWord[ch*SW +: SW]), 32'(expWord(ch)));
      checkOutput($sformatf("ref%0d@%0d", ch, cyc), 32'(pulseRef[ch]), 32'(expRef(ch)));
      checkOutput($sformatf("done%0d@%0d", ch, cyc), 32'(done[ch]), 32'(expDone(ch)));
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      step();
      checkAll();
    end
  endtask

  task automatic startChannels(input logic [7:0] m);
    busWrite(16'd1, m);
    for (int ch = 0; ch < NCH; ch++) if (m[ch]) chStart[ch] = cyc;
    checkAll();
  endtask

  task automatic stopChannels(input logic [7:0] m);
    busWrite(16'd2, m);
    for (int ch = 0; ch < NCH; ch++) if (m[ch]) chStart[ch] = -1;
    checkAll();
  endtask

  // Random settings on every channel, a random start mask, one random restart, then stop all.
  task automatic applyStimulus();
    longint d, w, p;
    busWrite(16'd0, 8'h00);
    modelReset();
    checkAll();
    for (int ch = 0; ch < NCH; ch++) begin
      d = longint'($urandom_range(0, 6));
      w = longint'($urandom_range(0, 5));
      p = longint'($urandom_range(0, 15));
      if (d + w == 0 && p == 0) p = 1;
      writeCfg(ch, d, w, p, longint'($urandom_range(0, 3)), longint'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)));
    end
    startChannels(8'($urandom_range(1, 15)));
    runCycles(20);
    startChannels(8'(1 << $urandom_range(0, NCH - 1)));
    runCycles(40);
    stopChannels(8'h0F);
  endtask

  initial begin
    logic [7:0] tbl [6];
    busIf.BUS_ADD = '0; busIf.BUS_DATA_IN = '0; busIf.BUS_RD = 1'b0; busIf.BUS_WR = 1'b0;
    modelReset();
    #2;
    checkOutput("rst_word", pulseWord, '0);
    checkOutput("rst_ref", 32'(pulseRef), 32'h0);
    checkOutput("rst_done", 32'(done), 32'hF);
    checkOutput("rst_dout", 32'(busIf.BUS_DATA_OUT), 32'h0);
    step();
    rstN = 1'b1;
    step();
    busRead(16'd0, rd);  checkOutput("version", 32'(rd), 32'h02);
    busRead(16'd46, rd); checkOutput("rst_repeat_lo", 32'(rd), 32'h01);
    busRead(16'd47, rd); checkOutput("rst_repeat_hi", 32'(rd), 32'h00);

    // Channel 0 single burst against a fixed expected word list.
    tbl = '{8'h00, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h00};
    writeCfg(0, 3, 2, 0, 1, 8'h0F, 1'b0);
    busWrite(16'd1, 8'h01);
    chStart[0] = cyc;
    checkOutput("tp0_busy", 32'(done[0]), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      checkOutput($sformatf("tp0_word%0d", k), 32'(pulseWord[7:0]), 32'(tbl[k]));
      checkOutput($sformatf("tp0_done%0d", k), 32'(done[0]), (k >= 4) ? 32'h1 : 32'h0);
    end
    busRead(16'd1, rd); checkOutput("done_reg", 32'(rd), 32'h0F);

    // Channel 1 repeats three times; the live counter reads back 1 right after start.
    writeCfg(1, 1, 1, 10, 3, 8'h5A, 1'b0);
    startChannels(8'h02);
    busRead(16'd82, rd); checkOutput("cnt_start", 32'(rd), 32'h01);
    runCycles(32);

    // Channel 2 runs forever until stopped; start followed by stop leaves it idle.
    writeCfg(2, 2, 3, 7, 0, 8'h33, 1'b0);
    startChannels(8'h04);
    runCycles(50);
    stopChannels(8'h04);
    checkOutput("stop_word", 32'(pulseWord[23:16]), 32'h0);
    checkOutput("stop_done", 32'(done[2]), 32'h1);
    runCycles(3);
    startChannels(8'h04);
    stopChannels(8'h04);
    runCycles(4);

    // Two concurrent channels, channel 3 inverted.
    writeCfg(0, 2, 4, 9, 2, 8'h81, 1'b0);
    writeCfg(3, 4, 3, 0, 3, 8'h3C, 1'b1);
    startChannels(8'h09);
    runCycles(40);

    // Asynchronous reset in the middle of a burst.
    writeCfg(1, 1, 5, 8, 0, 8'h11, 1'b0);
    startChannels(8'h02);
    runCycles(6);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("arst_word", pulseWord, '0);
    checkOutput("arst_done", 32'(done), 32'hF);
    checkOutput("arst_dout", 32'(busIf.BUS_DATA_OUT), 32'h0);
    modelReset();
    step();
    rstN = 1'b1;
    busRead(16'd78, rd); checkOutput("arst_repeat", 32'(rd), 32'h01);
    busRead(16'd66, rd); checkOutput("arst_delay", 32'(rd), 32'h00);

    // Soft reset through a write to address 0.
    writeCfg(0, 2, 2, 0, 0, 8'hAA, 1'b1);
    startChannels(8'h01);
    runCycles(5);
    busWrite(16'd0, 8'h00);
    modelReset();
    checkAll();
    busRead(16'd46, rd); checkOutput("srst_repeat", 32'(rd), 32'h01);
    busRead(16'd32, rd); checkOutput("srst_conf", 32'(rd), 32'h00);

    // External trigger on channel 1.
    writeCfg(1, 2, 3, 0, 1, 8'h77, 1'b0);
    busWrite(16'd64, 8'h01);
    busRead(16'd64, rd);
`ifdef PULSE_GEN_MULTI_EXT_TRIG_EN
    checkOutput("ext_en_rd", 32'(rd), 32'h01);
    extStart[1] = 1'b1;
    step(); checkOutput("ext_wait1", 32'(done[1]), 32'h1);
    step(); checkOutput("ext_wait2", 32'(done[1]), 32'h1);
    step(); checkOutput("ext_go", 32'(done[1]), 32'h0);
    chStart[1] = cyc;
    busRead(16'd82, rd); checkOutput("ext_cnt", 32'(rd), 32'h01);
    runCycles(8);
`else
    checkOutput("ext_en_rd", 32'(rd), 32'h00);
    extStart[1] = 1'b1;
    runCycles(6);
`endif
    extStart[1] = 1'b0;
    runCycles(2);
    busWrite(16'd64, 8'h00);
    extStart[1] = 1'b1;
    runCycles(6);
    extStart[1] = 1'b0;

    for (int it = 0; it < 5; it++) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
